// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers for the multiplier scheduling slice.
package fpu;

  localparam int FPU_SIG_WIDTH     = 24;
  localparam int FPU_PRODUCT_WIDTH = 48;
  // Wide enough for up to 8 requesters.
  localparam int FPU_OWNER_WIDTH   = 3;

  typedef struct packed {
    logic                         valid;
    logic [FPU_OWNER_WIDTH-1:0]   owner;
    logic [FPU_PRODUCT_WIDTH-1:0] product;
  } fpu_mult_stage_t;

  // Full-width unsigned significand product, no truncation.
  function automatic logic [FPU_PRODUCT_WIDTH-1:0] fpu_operations_multiply(
    input logic [FPU_SIG_WIDTH-1:0] a,
    input logic [FPU_SIG_WIDTH-1:0] b
  );
    return {{FPU_SIG_WIDTH{1'b0}}, a} * {{FPU_SIG_WIDTH{1'b0}}, b};
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr (mod N), ptr moves past the
// winner only when the grant is actually taken (advance).
module fpu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;
  int            j;

  // First requester at or after ptr, wrapping around, wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && request[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = PW'(j);
      end
    end
  end

  // Pointer moves to one past the requester that completed a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/fpu_mult_scheduler.sv
// Shares one pipelined 24x24 significand multiplier among NUM_REQ requesters.
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// and its payload are held by the source until then, and ready may depend on
// valid but never the other way round. The whole pipeline freezes while the
// output product is not accepted by its owner.
module fpu_mult_scheduler
  import fpu::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [FPU_SIG_WIDTH-1:0]     req_a [NUM_REQ],
  input  logic [FPU_SIG_WIDTH-1:0]     req_b [NUM_REQ],
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [FPU_PRODUCT_WIDTH-1:0] rsp_product,
  output logic                         idle
);

  fpu_mult_stage_t pipe [LATENCY];
  fpu_mult_stage_t out_st;

  logic [NUM_REQ-1:0]         grant;
  logic                       stall;
  logic                       issue;
  logic [FPU_SIG_WIDTH-1:0]   sel_a;
  logic [FPU_SIG_WIDTH-1:0]   sel_b;
  logic [FPU_OWNER_WIDTH-1:0] sel_owner;

  assign out_st = pipe[LATENCY-1];

  fpu_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .request (req_valid),
    .advance (!stall && !rst),
    .grant   (grant)
  );

  // Stall only when a valid output is refused by the requester that owns it.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_st.valid && (out_st.owner == FPU_OWNER_WIDTH'(i)) && !rsp_ready[i]) begin
        stall = 1'b1;
      end
    end
  end

  assign req_ready = (rst || stall) ? '0 : grant;
  assign issue     = |req_ready;

  // Select the granted requester's operands and encode its index.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a     = req_a[i];
        sel_b     = req_b[i];
        sel_owner = FPU_OWNER_WIDTH'(i);
      end
    end
  end

  // Stage 0 multiplies, later stages delay; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (!stall) begin
      pipe[0].valid   <= issue;
      pipe[0].owner   <= issue ? sel_owner : '0;
      pipe[0].product <= issue ? fpu_operations_multiply(sel_a, sel_b) : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Route the output valid to its owner only.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = out_st.valid && (out_st.owner == FPU_OWNER_WIDTH'(i));
    end
  end

  assign rsp_product = out_st.product;

  // Idle when no stage carries a valid operation.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      if (pipe[i].valid) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_mult_scheduler.sv
// Self-checking bench for fpu_mult_scheduler.
module tb_fpu_mult_scheduler;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 3;
  localparam int W       = 3 + 48;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [23:0]       req_a [NUM_REQ];
  logic [23:0]       req_b [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [47:0]       rsp_product;
  logic              idle;

  logic [W-1:0] exp_q [$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  fpu_mult_scheduler #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .idle        (idle)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] wa;
    logic [47:0] wb;
    wa = {24'd0, a};
    wb = {24'd0, b};
    return wa * wb;
  endfunction

  // Scoreboard: push on every accepted issue, pop on every accepted response.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) exp_q.push_back({3'(i), ref_mul(req_a[i], req_b[i])});
      end
      total_cnt++;
      if ($onehot0(rsp_valid)) pass_cnt++;
      else $display("FAIL rsp_onehot: got %b, need one-hot or zero", rsp_valid);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: got owner %0d product %h, need nothing outstanding", i, rsp_product);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({3'(i), rsp_product} !== e)
              $display("FAIL scoreboard: got owner %0d product %h, need owner %0d product %h",
                       i, rsp_product, e[W-1:48], e[47:0]);
            else pass_cnt++;
          end
        end
      end
    end
  end

  // Driver helpers: drive just after the rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int cnt;
    cnt = 0;
    while (!idle && cnt < bound) begin
      step();
      cnt++;
    end
    total_cnt++;
    if (idle === 1'b1) pass_cnt++;
    else $display("FAIL drain_timeout: got idle %b after %0d cycles, need 1", idle, cnt);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end
    step();
    sample();
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b, need 0000", req_ready);
    else pass_cnt++;
    step();
    sample();
    total_cnt++;
    if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b, need 0000", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_product !== 48'd0) $display("FAIL reset_rsp_product: got %h, need 0", rsp_product);
    else pass_cnt++;
    total_cnt++;
    if (idle !== 1'b1) $display("FAIL reset_idle: got %b, need 1", idle);
    else pass_cnt++;
    step();
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    int cnt;
    do_reset();
    req_a[2]  = 24'h800000;
    req_b[2]  = 24'h800000;
    req_valid = 4'b0100;
    sample();
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b, need 0100", req_ready);
    else pass_cnt++;
    step();
    req_valid = '0;
    cnt = 1;
    while (rsp_valid === 4'b0000 && cnt < 20) begin
      step();
      cnt++;
    end
    total_cnt++;
    if (cnt != LATENCY) $display("FAIL single_latency: got %0d cycles, need %0d", cnt, LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid: got %b, need 0100", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_product !== 48'h400000000000)
      $display("FAIL single_product: got %h, need 400000000000", rsp_product);
    else pass_cnt++;
    step();
    total_cnt++;
    if (idle !== 1'b1) $display("FAIL single_idle: got %b, need 1", idle);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic seen0;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = (i == 0) ? 24'hFFFFFF : 24'($urandom_range(24'h800000, 24'hFFFFFF));
      req_b[i] = (i == 0) ? 24'hFFFFFF : 24'($urandom_range(24'h800000, 24'hFFFFFF));
    end
    req_valid = '1;
    rsp_ready = '1;
    seen0     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample();
      total_cnt++;
      if (req_ready !== 4'(1 << (k % 4)))
        $display("FAIL rr_grant_%0d: got %b, need %b", k, req_ready, 4'(1 << (k % 4)));
      else pass_cnt++;
      if (rsp_valid[0] && !seen0) begin
        seen0 = 1'b1;
        total_cnt++;
        if (rsp_product !== 48'hFFFFFE000001)
          $display("FAIL rr_max_product: got %h, need fffffe000001", rsp_product);
        else pass_cnt++;
      end
      step();
    end
    req_valid = '0;
    total_cnt++;
    if (!seen0) $display("FAIL rr_first_response: got none from requester 0, need one");
    else pass_cnt++;
    wait_idle(40);
  endtask

  task automatic test_back_to_back_backpressure();
    logic [23:0] a_ops [5];
    logic [23:0] b_ops [5];
    logic [47:0] held;
    int sent;
    int stall_left;
    int cyc;
    logic seen;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_ops[i] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
      b_ops[i] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    end
    sent = 0; stall_left = 0; cyc = 0; seen = 1'b0; held = '0;
    req_a[1]  = a_ops[0];
    req_b[1]  = b_ops[0];
    req_valid = 4'b0010;
    rsp_ready = '1;
    while ((sent < 5 || !idle || stall_left > 0) && cyc < 80) begin
      if (rsp_valid[1] && !seen) begin
        seen       = 1'b1;
        stall_left = 4;
        held       = rsp_product;
      end
      rsp_ready[1] = (stall_left == 0);
      sample();
      if (req_ready[1]) sent++;
      if (stall_left > 0) begin
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL bp_req_ready: got %b, need 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 4'b0010) $display("FAIL bp_rsp_valid: got %b, need 0010", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_product !== held) $display("FAIL bp_product_hold: got %h, need %h", rsp_product, held);
        else pass_cnt++;
        stall_left--;
      end
      step();
      cyc++;
      if (sent < 5) begin
        req_valid = 4'b0010;
        req_a[1]  = a_ops[sent];
        req_b[1]  = b_ops[sent];
      end else begin
        req_valid = '0;
      end
    end
    rsp_ready = '1;
    total_cnt++;
    if (sent != 5 || !idle) $display("FAIL bp_complete: got %0d issued idle %b, need 5 issued idle 1", sent, idle);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL bp_outstanding: got %0d left, need 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_non_owner_ready();
    int cnt;
    do_reset();
    rsp_ready = 4'b1110;
    req_a[0] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    req_b[0] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    req_a[1] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    req_b[1] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    req_valid = 4'b0011;
    sample();
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL nonowner_issue0: got %b, need 0001", req_ready);
    else pass_cnt++;
    step();
    req_valid = 4'b0010;
    sample();
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL nonowner_issue1: got %b, need 0010", req_ready);
    else pass_cnt++;
    step();
    req_valid = '0;
    cnt = 0;
    while (!rsp_valid[0] && cnt < 20) begin
      step();
      cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      sample();
      total_cnt++;
      if (rsp_valid !== 4'b0001) $display("FAIL nonowner_stall_%0d: got %b, need 0001", k, rsp_valid);
      else pass_cnt++;
      step();
    end
    rsp_ready = 4'b1111;
    sample();
    step();
    total_cnt++;
    if (rsp_valid !== 4'b0010) $display("FAIL nonowner_resume: got %b, need 0010", rsp_valid);
    else pass_cnt++;
    wait_idle(20);
  endtask

  task automatic test_reset_midflight();
    logic any_rsp;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
      req_b[i] = 24'($urandom_range(24'h800000, 24'hFFFFFF));
    end
    req_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      sample();
      step();
    end
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (idle !== 1'b1) $display("FAIL midrst_idle: got %b, need 1", idle);
    else pass_cnt++;
    any_rsp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (rsp_valid !== 4'b0000) any_rsp = 1'b1;
      step();
    end
    total_cnt++;
    if (any_rsp) $display("FAIL midrst_dropped: got a response after reset, need none");
    else pass_cnt++;
    req_valid = '1;
    sample();
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL midrst_first_grant: got %b, need 0001", req_ready);
    else pass_cnt++;
    step();
    req_valid = '0;
    wait_idle(20);
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    req_valid = 4'b0100;
    sample();
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL wrap_prime: got %b, need 0100", req_ready);
    else pass_cnt++;
    step();
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      sample();
      total_cnt++;
      if (req_ready !== ((k % 2 == 0) ? 4'b1000 : 4'b0001))
        $display("FAIL wrap_grant_%0d: got %b, need %b", k, req_ready, (k % 2 == 0) ? 4'b1000 : 4'b0001);
      else pass_cnt++;
      step();
    end
    req_valid = '0;
    wait_idle(20);
  endtask

  // Test sequence and final report.
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_backpressure();
    test_non_owner_ready();
    test_reset_midflight();
    test_pointer_wrap();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL final_outstanding: got %0d left, need 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
